// File: rtl/hs32_fetch_pkg.sv
// Shared HS32 core constants: fetch FSM encoding, reset vector, PC step.
package hs32_fetch_pkg;

  localparam int unsigned XLEN = 32;

  // Default fetch address out of reset
  localparam logic [XLEN-1:0] HS32_RESET_PC = 32'h0000_0000;

  // Fetch advances one 32-bit word at a time
  localparam logic [XLEN-1:0] HS32_PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_BUSY  = 2'd1,
    FETCH_DRAIN = 2'd2
  } fetch_state_e;

  // Sequential successor of a fetch address (wraps modulo 2^32)
  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
    return pc + HS32_PC_STEP;
  endfunction

endpackage

// File: rtl/hs32_ifq.sv
// Parameterised synchronous FIFO with clear; clear wins over push/pop.
module hs32_ifq #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // Pointer, storage and occupancy update
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // FIFO registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/hs32_fetch.sv
// HS32 instruction fetch: PC, memory read requests, prefetch queue to decode.
module hs32_fetch
  import hs32_fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] RESET_PC = HS32_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] newpc,
  input  logic        flush,
  output logic [31:0] addr,
  input  logic [31:0] dtrm,
  output logic        reqm,
  input  logic        rdym,
  output logic [31:0] instd,
  output logic        reqd,
  input  logic        rdyd
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_e  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   addr_q, addr_d;
  logic          reqm_q, reqm_d;
  logic          push_c;
  logic          pop_c;
  logic          slot_free_c;
  logic [CW-1:0] count_c;

  assign slot_free_c = (count_c < CW'(DEPTH));

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH_IDLE;
    else       state_q <= state_d;
  end

  // Next-state: a started bus cycle always completes before returning to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH_IDLE:  if (!flush && slot_free_c) state_d = FETCH_BUSY;
      FETCH_BUSY:  if (rdym) state_d = FETCH_IDLE;
                   else if (flush) state_d = FETCH_DRAIN;
      FETCH_DRAIN: if (rdym) state_d = FETCH_IDLE;
      default:     state_d = FETCH_IDLE;
    endcase
  end

  // Datapath controls: PC redirect, request launch/retire, queue push
  always_comb begin
    pc_d   = pc_q;
    addr_d = addr_q;
    reqm_d = reqm_q;
    push_c = 1'b0;
    case (state_q)
      FETCH_IDLE: begin
        if (flush) begin
          pc_d = newpc;
        end else if (slot_free_c) begin
          addr_d = pc_q;
          reqm_d = 1'b1;
        end
      end
      FETCH_BUSY: begin
        if (flush) pc_d = newpc;
        if (rdym) begin
          reqm_d = 1'b0;
          if (!flush) begin
            push_c = 1'b1;
            pc_d   = next_pc(pc_q);
          end
        end
      end
      FETCH_DRAIN: begin
        if (flush) pc_d = newpc;
        if (rdym)  reqm_d = 1'b0;
      end
      default: begin
        reqm_d = 1'b0;
      end
    endcase
  end

  // Fetch datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q   <= RESET_PC;
      addr_q <= RESET_PC;
      reqm_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      addr_q <= addr_d;
      reqm_q <= reqm_d;
    end
  end

  assign pop_c = reqd && rdyd;

  hs32_ifq #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_ifq (
    .clk   (clk),
    .reset (reset),
    .push  (push_c),
    .pop   (pop_c),
    .clear (flush),
    .din   (dtrm),
    .dout  (instd),
    .count (count_c)
  );

  assign addr = addr_q;
  assign reqm = reqm_q;
  assign reqd = (count_c != '0);

endmodule

// File: tb/tb_hs32_fetch.sv
// Bench for hs32_fetch: directed scenarios plus randomized traffic, with a
// scoreboard of the decode word stream fed from a word-stream reference model.
module tb_hs32_fetch;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] newpc = 32'h0;
  logic        flush = 1'b0;
  logic        rdym  = 1'b0;
  logic        rdyd  = 1'b0;
  logic [31:0] addr, instd, dtrm;
  logic        reqm, reqd;

  logic [31:0] addr2, instd2, dtrm2;
  logic        reqm2, reqd2;

  // Memory: every word reads back as its address xor KEY
  assign dtrm  = addr ^ KEY;
  assign dtrm2 = addr2 ^ KEY;

  hs32_fetch #(.DEPTH(2), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .newpc(newpc), .flush(flush),
    .addr(addr), .dtrm(dtrm), .reqm(reqm), .rdym(rdym),
    .instd(instd), .reqd(reqd), .rdyd(rdyd)
  );

  hs32_fetch #(.DEPTH(2), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .reset(reset), .newpc(32'h0), .flush(1'b0),
    .addr(addr2), .dtrm(dtrm2), .reqm(reqm2), .rdym(1'b1),
    .instd(instd2), .reqd(reqd2), .rdyd(1'b1)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int xfers  = 0;
  int reads  = 0;
  logic [31:0] rd_addrs [$];
  logic [31:0] exp_q [$];
  logic [31:0] next_exp;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_addr = 32'h0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Reference: decode sees consecutive words from the latest start address
  task automatic sb_refill();
    while (exp_q.size() < 8) begin
      exp_q.push_back(next_exp ^ KEY);
      next_exp = next_exp + 32'd4;
    end
  endtask

  task automatic sb_restart(input logic [31:0] start);
    exp_q.delete();
    next_exp = start;
    sb_refill();
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
    sb_refill();
  endtask

  // Monitor: decode transfers vs scoreboard, bus read log, request hold rule
  always @(negedge clk) begin
    if (reset) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("reqm_hold", 32'(reqm), 32'd1);
        check("addr_hold", addr, prev_addr);
      end
      if (reqm && rdym) begin
        reads++;
        rd_addrs.push_back(addr);
      end
      if (reqd && rdyd && !flush) begin
        xfers++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL decode_word: got %h expected <none queued>", instd);
        end else begin
          check("decode_word", instd, exp_q.pop_front());
        end
      end
      prev_hold = reqm && !rdym;
      prev_addr = addr;
    end
  end

  initial begin
    int x0;
    logic [31:0] a0;
    logic [31:0] a1;

    // Reset state and zero-wait streaming
    rdym = 1'b1;
    rdyd = 1'b1;
    sb_restart(32'h0);
    tick();
    tick();
    check("rst_reqm", 32'(reqm), 32'd0);
    check("rst_reqd", 32'(reqd), 32'd0);
    check("rst_instd", instd, 32'h0);
    check("rst_addr", addr, 32'h0);
    check("rst_addr_wrap", addr2, 32'hFFFF_FFF8);
    reset = 1'b0;
    tick();
    check("e1_reqm", 32'(reqm), 32'd1);
    check("e1_addr", addr, 32'h0);
    check("e1_reqd", 32'(reqd), 32'd0);
    check("e1_addr_wrap", addr2, 32'hFFFF_FFF8);
    tick();
    check("e2_reqd", 32'(reqd), 32'd1);
    check("e2_instd", instd, 32'hA5A5_0000);
    check("e2_reqm", 32'(reqm), 32'd0);
    check("e2_reqd_wrap", 32'(reqd2), 32'd1);
    check("e2_instd_wrap", instd2, 32'h5A5A_FFF8);
    tick();
    check("e3_reqd", 32'(reqd), 32'd0);
    check("e3_addr", addr, 32'h4);
    check("e3_addr_wrap", addr2, 32'hFFFF_FFFC);
    tick();
    check("e4_instd", instd, 32'hA5A5_0004);
    tick();
    check("e5_addr", addr, 32'h8);
    check("e5_addr_wrap", addr2, 32'h0);
    check("e5_reqm_wrap", 32'(reqm2), 32'd1);
    tick();
    check("e6_instd", instd, 32'hA5A5_0008);
    tick();
    tick();
    check("e8_instd", instd, 32'hA5A5_000C);

    // Asynchronous reset while a read is outstanding
    rdyd = 1'b0;
    tick();
    check("pre_rst_reqm", 32'(reqm), 32'd1);
    reset = 1'b1;
    sb_restart(32'h0);
    #1;
    check("arst_reqm", 32'(reqm), 32'd0);
    check("arst_reqd", 32'(reqd), 32'd0);
    check("arst_addr", addr, 32'h0);
    check("arst_instd", instd, 32'h0);
    tick();
    reset = 1'b0;
    reads = 0;
    rd_addrs.delete();
    tick();
    check("restart_reqm", 32'(reqm), 32'd1);
    check("restart_addr", addr, 32'h0);

    // Decode stalled: queue fills after two reads, then fetch stops
    repeat (18) tick();
    check("stall_reads", 32'(reads), 32'd2);
    a0 = (rd_addrs.size() > 0) ? rd_addrs[0] : 32'hDEAD_BEEF;
    a1 = (rd_addrs.size() > 1) ? rd_addrs[1] : 32'hDEAD_BEEF;
    check("stall_addr0", a0, 32'h0);
    check("stall_addr1", a1, 32'h4);
    check("stall_reqm", 32'(reqm), 32'd0);
    check("stall_reqd", 32'(reqd), 32'd1);
    rdyd = 1'b1;
    tick();
    tick();
    check("third_reqm", 32'(reqm), 32'd1);
    check("third_addr", addr, 32'h8);

    // Flush while BUSY with memory stalled: old cycle drains, data dropped
    reset = 1'b1;
    rdym  = 1'b0;
    sb_restart(32'h0);
    tick();
    reset = 1'b0;
    tick();
    check("fb_reqm", 32'(reqm), 32'd1);
    flush = 1'b1;
    newpc = 32'h100;
    sb_restart(32'h100);
    tick();
    flush = 1'b0;
    check("drain_reqm", 32'(reqm), 32'd1);
    check("drain_addr", addr, 32'h0);
    tick();
    tick();
    check("drain_addr_late", addr, 32'h0);
    rdym = 1'b1;
    tick();
    check("drained_reqm", 32'(reqm), 32'd0);
    check("drained_reqd", 32'(reqd), 32'd0);
    tick();
    check("redir_reqm", 32'(reqm), 32'd1);
    check("redir_addr", addr, 32'h100);

    // Flush coinciding with rdym and a decode pop, one entry queued
    rdyd = 1'b0;
    tick();
    check("redir_instd", instd, 32'hA5A5_0100);
    tick();
    check("busy_reqm", 32'(reqm), 32'd1);
    check("busy_reqd", 32'(reqd), 32'd1);
    rdyd  = 1'b1;
    flush = 1'b1;
    newpc = 32'h200;
    sb_restart(32'h200);
    tick();
    flush = 1'b0;
    check("cflush_reqd", 32'(reqd), 32'd0);
    check("cflush_reqm", 32'(reqm), 32'd0);
    tick();
    check("cflush_reqm2", 32'(reqm), 32'd1);
    check("cflush_addr", addr, 32'h200);

    // Randomized traffic against the word-stream model
    x0 = xfers;
    for (int i = 0; i < 3000; i++) begin
      rdym = ($urandom_range(0, 2) != 0);
      rdyd = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 24) == 0) begin
        flush = 1'b1;
        newpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom() & 32'hFFFF_FFFC);
        sb_restart(newpc);
      end else begin
        flush = 1'b0;
      end
      tick();
    end
    flush = 1'b0;
    rdym  = 1'b1;
    rdyd  = 1'b1;
    repeat (12) tick();
    check("random_progress", 32'(xfers - x0 > 200), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
